// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the pipeline and the multiply/divide sequencer.
// Handshake: start is a request accepted on any edge where the engine is not BUSY; done is the one-cycle response.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             w2_en;
  logic             err;

  modport master (
    output start, op_div, op_a, op_b,
    input  stall, busy, done, result_lo, result_hi, w2_en, err
  );

  modport slave (
    input  start, op_div, op_a, op_b,
    output stall, busy, done, result_lo, result_hi, w2_en, err
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide, one step per clock, WIDTH steps per op.
// Optional build macro MULDIV_SIGNED_EN: two's-complement operands with sign fixup on entry to DONE.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH-1:0] mcand;   // multiplicand or divisor
  logic [WIDTH-1:0] acc;     // product upper half or partial remainder
  logic [WIDTH-1:0] mplr;    // multiplier / product lower half, or quotient

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             last;

  always_comb begin
    mul_sum  = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    rem_sh   = {acc, mplr[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand};
    if (div_q) begin
      // Top bit of the difference is the borrow: set means rem < divisor.
      if (!rem_diff[WIDTH]) begin
        nxt_hi = rem_diff[WIDTH-1:0];
        nxt_lo = {mplr[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {mplr[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], mplr[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic               neg_p;  // product sign, or quotient sign for divide
  logic               neg_r;  // remainder follows the dividend
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;

  always_comb begin
    mag_a  = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    mag_b  = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    prod   = {nxt_hi, nxt_lo};
    prod_f = neg_p ? -prod : prod;
    if (div_q) begin
      fix_lo = neg_p ? -nxt_lo : nxt_lo;
      fix_hi = neg_r ? -nxt_hi : nxt_hi;
    end else begin
      fix_lo = prod_f[WIDTH-1:0];
      fix_hi = prod_f[2*WIDTH-1:WIDTH];
    end
  end
`else
  always_comb begin
    mag_a  = bus.op_a;
    mag_b  = bus.op_b;
    fix_lo = nxt_lo;
    fix_hi = nxt_hi;
  end
`endif

  assign last      = (cnt == CW'(WIDTH - 1));
  assign bus.stall = (state == S_BUSY) | bus.start;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      div_q         <= 1'b0;
      mcand         <= '0;
      acc           <= '0;
      mplr          <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.w2_en     <= 1'b0;
      bus.err       <= 1'b0;
      bus.result_lo <= '0;
      bus.result_hi <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_p         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        S_BUSY: begin
          acc  <= nxt_hi;
          mplr <= nxt_lo;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.w2_en     <= 1'b1;
            bus.err       <= 1'b0;
            bus.result_lo <= fix_lo;
            bus.result_hi <= fix_hi;
          end
        end
        default: begin
          if (bus.start) begin
            div_q <= bus.op_div;
            cnt   <= '0;
            acc   <= '0;
            mcand <= bus.op_div ? mag_b : mag_a;
            mplr  <= bus.op_div ? mag_a : mag_b;
`ifdef MULDIV_SIGNED_EN
            neg_p <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            neg_r <= bus.op_a[WIDTH-1];
`endif
            if (bus.op_div && (bus.op_b == '0)) begin
              // Divide-by-zero skips the iteration and reports immediately.
              state         <= S_DONE;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.w2_en     <= 1'b1;
              bus.err       <= 1'b1;
              bus.result_lo <= '1;
              bus.result_hi <= bus.op_a;
            end else begin
              state     <= S_BUSY;
              bus.busy  <= 1'b1;
              bus.done  <= 1'b0;
              bus.w2_en <= 1'b0;
              bus.err   <= 1'b0;
            end
          end else begin
            state     <= S_IDLE;
            bus.done  <= 1'b0;
            bus.w2_en <= 1'b0;
            bus.err   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus hand-written back-to-back and abort sequences.
module tb_muldiv_sequencer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         op_div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         err;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [2*W:0] exp_q[$];   // {err, hi, lo}

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) chk("busy_done_exclusive", {32'd0, bus.busy & bus.done}, 33'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present start for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = d;
    bus.op_a   = a;
    bus.op_b   = b;
    #1 chk("stall_on_request", {32'd0, bus.stall}, 33'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom_range(0, 65535));
    bus.op_b  = W'($urandom_range(0, 65535));
  endtask

  // Waits for done, checking latency and popping the expected result.
  task automatic wait_done(input int exp_lat);
    int lat;
    logic [2*W:0] e;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk("busy_in_flight", {32'd0, bus.busy}, 33'd1);
      if (lat == 5) begin
        bus.start = 1'b1;
        bus.op_b  = W'($urandom_range(0, 65535));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk("done_seen", {32'd0, bus.done}, 33'd1);
    chk("latency", 33'(lat), 33'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("result_lo", {17'd0, bus.result_lo}, {17'd0, e[W-1:0]});
    chk("result_hi", {17'd0, bus.result_hi}, {17'd0, e[2*W-1:W]});
    chk("err", {32'd0, bus.err}, {32'd0, e[2*W]});
    chk("w2_en", {32'd0, bus.w2_en}, 33'd1);
    chk("busy_in_done", {32'd0, bus.busy}, 33'd0);
    #1 chk("stall_in_done", {32'd0, bus.stall}, 33'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [W-1:0] lo, hi;
    exp_q.push_back({v.err, v.hi, v.lo});
    issue(v.op_div, v.a, v.b);
    wait_done((v.op_div && v.b == '0) ? 1 : 17);
    lo = bus.result_lo;
    hi = bus.result_hi;
    @(negedge clk);
    chk({v.name, "_done_pulse"}, {32'd0, bus.done | bus.w2_en}, 33'd0);
    chk({v.name, "_hold_lo"}, {17'd0, lo}, {17'd0, v.lo});
    chk({v.name, "_hold_hi"}, {17'd0, bus.result_hi}, {17'd0, hi});
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    bit saw_done;

    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    rst_n      = 1'b0;

`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{"mul_3x5",      1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0});
    vecs.push_back('{"sdiv_m7_2",    1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0});
    vecs.push_back('{"smul_m3x4",    1'b0, 16'hFFFD, 16'h0004, 16'hFFF4, 16'hFFFF, 1'b0});
    vecs.push_back('{"sdiv_min_m1",  1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
    vecs.push_back('{"sdiv_7_m2",    1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0});
    vecs.push_back('{"smul_m1xm1",   1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
    vecs.push_back('{"div_100_7",    1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
    vecs.push_back('{"div_by_zero",  1'b1, 16'h0007, 16'h0000, 16'hFFFF, 16'h0007, 1'b1});
`else
    vecs.push_back('{"mul_3x5",      1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0});
    vecs.push_back('{"mul_ffff_sq",  1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0});
    vecs.push_back('{"div_100_7",    1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
    vecs.push_back('{"mul_zero",     1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"mul_by_one",   1'b0, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 1'b0});
    vecs.push_back('{"mul_carry",    1'b0, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0});
    vecs.push_back('{"mul_1234_5678",1'b0, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0});
    vecs.push_back('{"div_max_1",    1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{"div_small",    1'b1, 16'h0005, 16'h000A, 16'h0000, 16'h0005, 1'b0});
    vecs.push_back('{"div_max_max",  1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
    vecs.push_back('{"div_1234_12",  1'b1, 16'h1234, 16'h0012, 16'h0102, 16'h0010, 1'b0});
    vecs.push_back('{"div_by_zero",  1'b1, 16'h0007, 16'h0000, 16'hFFFF, 16'h0007, 1'b1});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {31'd0, dbg_state}, 33'd0);
    chk("rst_flags", {28'd0, bus.busy, bus.done, bus.w2_en, bus.err, bus.stall}, 33'd0);
    chk("rst_results", {1'b0, bus.result_hi, bus.result_lo}, 33'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: divide-by-zero presented while DONE skips BUSY
    exp_q.push_back({1'b0, 16'h0000, 16'h000F});
    issue(1'b0, 16'h0003, 16'h0005);
    wait_done(17);
    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    bus.op_a   = 16'h0010;
    bus.op_b   = 16'h0000;
    #1 chk("b2b_stall_in_done", {32'd0, bus.stall}, 33'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_state", {31'd0, dbg_state}, 33'd2);
    chk("b2b_done", {31'd0, bus.done, bus.busy}, 33'd2);
    chk("b2b_err", {32'd0, bus.err}, 33'd1);
    chk("b2b_lo", {17'd0, bus.result_lo}, {17'd0, 16'hFFFF});
    chk("b2b_hi", {17'd0, bus.result_hi}, {17'd0, 16'h0010});

    // Back-to-back: a multiply accepted straight out of DONE
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.op_a   = 16'h0002;
    bus.op_b   = 16'h0003;
    exp_q.push_back({1'b0, 16'h0000, 16'h0006});
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b2_busy", {32'd0, bus.busy}, 33'd1);
    wait_done(17);

    // Reset during BUSY cycle 8 aborts without a done pulse
    issue(1'b0, 16'h1234, 16'h5678);
    repeat (7) @(negedge clk);
    chk("abort_busy_before", {32'd0, bus.busy}, 33'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_state", {31'd0, dbg_state}, 33'd0);
    chk("abort_flags", {28'd0, bus.busy, bus.done, bus.w2_en, bus.err, bus.stall}, 33'd0);
    chk("abort_results", {1'b0, bus.result_hi, bus.result_lo}, 33'd0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    chk("abort_no_done", {32'd0, saw_done}, 33'd0);
    v = '{"after_abort", 1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0};
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
